// File: rtl/reg_dump_uart_tx.sv
// reg_dump_uart_tx: snapshots R0..R3/R7 on start and sends them as a 22-byte UART 8N1 frame
// (0xA5 header, 20 data bytes MSB-first per word, XOR checksum).
module reg_dump_uart_tx #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] r0_in,
    input  logic [31:0] r1_in,
    input  logic [31:0] r2_in,
    input  logic [31:0] r3_in,
    input  logic [31:0] r7_in,
    output logic        tx,
    output logic        busy,
    output logic        done
);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t         state;
    logic [159:0]   snap;
    logic [159:0]   snap_shifted;
    logic [4:0]     byte_idx;
    logic [2:0]     bit_idx;
    logic [CW-1:0]  cnt;
    logic [7:0]     csum;
    logic [7:0]     cur_byte;
    logic           bit_end;

    // Data byte k (1..20) sits at the top of the snapshot after shifting left by k-1 bytes.
    always_comb begin
        csum = '0;
        for (int i = 0; i < 20; i++) csum ^= snap[8*i +: 8];
        snap_shifted = snap << {byte_idx - 5'd1, 3'b000};
        cur_byte = (byte_idx == 5'd0)  ? 8'hA5 :
                   (byte_idx == 5'd21) ? csum  : snap_shifted[159:152];
        bit_end = (cnt == LAST);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            tx       <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
            snap     <= '0;
            byte_idx <= '0;
            bit_idx  <= '0;
            cnt      <= '0;
        end else begin
            done <= 1'b0;
            cnt  <= (state == IDLE || bit_end) ? '0 : cnt + 1'b1;
            case (state)
                IDLE: if (start) begin
                    snap     <= {r0_in, r1_in, r2_in, r3_in, r7_in};
                    state    <= START;
                    tx       <= 1'b0;
                    busy     <= 1'b1;
                    byte_idx <= '0;
                    bit_idx  <= '0;
                end
                START: if (bit_end) begin
                    state <= DATA;
                    tx    <= cur_byte[0];
                end
                DATA: if (bit_end) begin
                    if (bit_idx == 3'd7) begin
                        state <= STOP;
                        tx    <= 1'b1;
                    end else begin
                        bit_idx <= bit_idx + 3'd1;
                        tx      <= cur_byte[bit_idx + 3'd1];
                    end
                end
                STOP: if (bit_end) begin
                    bit_idx <= '0;
                    if (byte_idx == 5'd21) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        byte_idx <= byte_idx + 5'd1;
                        state    <= START;
                        tx       <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_reg_dump_uart_tx.sv
// tb_reg_dump_uart_tx: scoreboard bench; a UART decoder on tx pops expected frame bytes,
// a second monitor checks busy length and done pulses.
module tb_reg_dump_uart_tx;
    localparam int CPB   = 4;
    localparam int FRAME = 220 * CPB;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [31:0] r0_in = '0, r1_in = '0, r2_in = '0, r3_in = '0, r7_in = '0;
    logic        tx, busy, done;

    always #5 clk = ~clk;

    reg_dump_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk(clk), .reset(reset), .start(start),
        .r0_in(r0_in), .r1_in(r1_in), .r2_in(r2_in), .r3_in(r3_in), .r7_in(r7_in),
        .tx(tx), .busy(busy), .done(done)
    );

    int         checks = 0;
    int         errors = 0;
    int         done_cnt = 0;
    logic [7:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Reference frame: header, each word big-endian, then XOR of the 20 data bytes.
    function automatic void push_frame(input logic [31:0] a, b, c, d, e);
        logic [31:0] w[5];
        logic [7:0]  x, cs;
        w = '{a, b, c, d, e};
        cs = 8'h00;
        exp_q.push_back(8'hA5);
        foreach (w[k])
            for (int j = 3; j >= 0; j--) begin
                x = 8'(w[k] >> (8 * j));
                exp_q.push_back(x);
                cs ^= x;
            end
        exp_q.push_back(cs);
    endfunction

    // UART decoder: every cycle of a bit must match the bit's first cycle.
    logic       in_byte = 1'b0;
    int         pos = 0;
    logic [9:0] v;
    logic       width_bad;
    always @(negedge clk) begin
        if (reset) in_byte = 1'b0;
        else if (!in_byte) begin
            if (tx === 1'b0) begin
                in_byte = 1'b1;
                pos = 1;
                v = '0;
                width_bad = 1'b0;
                chk("busy_during_byte", 32'(busy), 32'd1);
            end
        end else begin
            if (pos % CPB == 0) v[pos / CPB] = tx;
            else if (tx !== v[pos / CPB]) width_bad = 1'b1;
            pos++;
            if (pos == 10 * CPB) begin
                in_byte = 1'b0;
                chk("bit_width", 32'(width_bad), 32'd0);
                chk("stop_bit", 32'(v[9]), 32'd1);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_byte actual=%h required=none", v[8:1]);
                end else chk("byte", 32'(v[8:1]), 32'(exp_q.pop_front()));
            end
        end
    end

    // Busy/done monitor.
    logic prev_busy = 1'b0, prev_done = 1'b0;
    int   bcnt = 0;
    always @(negedge clk) begin
        if (reset) begin
            bcnt = 0;
            if (done !== 1'b0) begin
                checks++;
                errors++;
                $display("FAIL done_in_reset actual=%b required=0", done);
            end
        end else begin
            if (busy) bcnt = prev_busy ? bcnt + 1 : 1;
            if (done === 1'b1) done_cnt++;
            if (prev_busy && !busy) begin
                chk("done_at_end", 32'(done), 32'd1);
                chk("busy_length", 32'(bcnt), 32'(FRAME));
            end else if (done === 1'b1) begin
                checks++;
                errors++;
                $display("FAIL spurious_done actual=1 required=0");
            end
            if (done === 1'b1 && prev_done) begin
                checks++;
                errors++;
                $display("FAIL done_width actual=2+ required=1");
            end
        end
        prev_busy = busy;
        prev_done = done;
    end

    task automatic launch(input logic [31:0] a, b, c, d, e);
        r0_in = a; r1_in = b; r2_in = c; r3_in = d; r7_in = e;
        start = 1'b1;
        push_frame(a, b, c, d, e);
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("latency_tx", 32'(tx), 32'd0);
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (done !== 1'b1 && n < FRAME + 20);
        chk(name, 32'(done), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_tx", 32'(tx), 32'd1);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_tx", 32'(tx), 32'd1);

        launch(32'h11223344, 0, 0, 0, 0);
        wait_done("basic_done");

        repeat (5) @(negedge clk);
        launch(32'h01020304, 32'h55AA55AA, 32'h0, 32'hFFFFFFFF, 32'hDEADBEEF);
        r7_in = 32'h0;
        wait_done("snapshot_done");

        repeat (5) @(negedge clk);
        launch(32'hCAFEF00D, 32'h12345678, 32'h9ABCDEF0, 32'h0F0F0F0F, 32'h00000001);
        repeat (100) @(negedge clk);
        r0_in = 32'hFFFFFFFF; r7_in = 32'h77777777;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done("ignored_start_done");
        repeat (50) @(negedge clk);
        chk("no_restart_busy", 32'(busy), 32'd0);
        chk("no_restart_queue", 32'(exp_q.size()), 32'd0);

        launch(32'hA1B2C3D4, 32'hE5F60718, 32'h293A4B5C, 32'h6D7E8F90, 32'h13579BDF);
        repeat (300) @(negedge clk);
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        chk("abort_tx", 32'(tx), 32'd1);
        chk("abort_busy", 32'(busy), 32'd0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        chk("abort_no_done", 32'(done_cnt), 32'd3);
        @(posedge clk); #1;
        reset = 1'b0;
        launch(32'h0BADF00D, 32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444);
        wait_done("after_reset_done");

        launch(32'h87654321, 32'h0, 32'h1, 32'h2, 32'h3);
        wait_done("b2b_first_done");
        launch(32'hFEDCBA98, 32'h76543210, 32'hAAAAAAAA, 32'h55555555, 32'h80000001);
        wait_done("b2b_second_done");

        repeat (5) @(negedge clk);
        r0_in = 32'h5A5A5A5A; r1_in = 32'h1; r2_in = 32'h2; r3_in = 32'h3; r7_in = 32'h4;
        push_frame(32'h5A5A5A5A, 32'h1, 32'h2, 32'h3, 32'h4);
        push_frame(32'h5A5A5A5A, 32'h1, 32'h2, 32'h3, 32'h4);
        start = 1'b1;
        wait_done("held_first_done");
        repeat (10) @(negedge clk);
        start = 1'b0;
        wait_done("held_second_done");

        for (int i = 0; i < 4; i++) begin
            if (i % 2 == 0) repeat ($urandom_range(1, 8)) @(negedge clk);
            launch($urandom, $urandom, $urandom, $urandom, $urandom);
            wait_done("random_done");
        end

        repeat (20) @(negedge clk);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        chk("done_count", 32'(done_cnt), 32'd12);
        chk("final_idle_tx", 32'(tx), 32'd1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
